// File: rtl/name_run_encoder.sv
// Run-length encoder for 128-bit name words; emits {word, count[31:0]} records, splitting runs at MAX_RUN.
// Optional per-block statistics counters are enabled by defining NAME_ENC_STATS_EN.
module name_run_encoder #(
  parameter int          DATA_W  = 128,
  parameter logic [31:0] MAX_RUN = 32'hFFFF_FFFF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W+31:0] out_data,
  output logic               busy
`ifdef NAME_ENC_STATS_EN
  ,
  output logic [31:0]        words_in,
  output logic [31:0]        records_out
`endif
);

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic [31:0]         cnt_q, cnt_d;
  logic                out_vld_q, out_vld_d;
  logic [DATA_W+31:0]  out_dat_q, out_dat_d;

  logic                slot_free;
  logic                accept;
  logic                same_word;
  logic                at_max;
  logic                load;
  logic [DATA_W-1:0]   load_word;
  logic [31:0]         load_cnt;

  assign slot_free = !out_vld_q || out_ready;
  assign in_ready  = slot_free && (state_q != FLUSH);
  assign accept    = in_valid && in_ready;
  assign same_word = (in_data == word_q);
  assign at_max    = (cnt_q >= MAX_RUN);

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    cnt_d     = cnt_q;
    out_vld_d = out_vld_q && !out_ready;
    out_dat_d = out_dat_q;
    load      = 1'b0;
    load_word = word_q;
    load_cnt  = cnt_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          word_d = in_data;
          cnt_d  = 32'd1;
          if (in_last) begin
            load      = 1'b1;
            load_word = in_data;
            load_cnt  = 32'd1;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (accept) begin
          if (same_word && !at_max) begin
            cnt_d = cnt_q + 32'd1;
            if (in_last) begin
              load     = 1'b1;
              load_cnt = cnt_q + 32'd1;
              state_d  = IDLE;
            end
          end else begin
            // Close the current run; the incoming beat opens a fresh one.
            load   = 1'b1;
            word_d = in_data;
            cnt_d  = 32'd1;
            if (in_last) state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (slot_free) begin
          load    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Every load happens with the slot free, so reloading over a draining record never drops data.
    if (load) begin
      out_vld_d = 1'b1;
      out_dat_d = {load_word, load_cnt};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      word_q    <= '0;
      cnt_q     <= '0;
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      cnt_q     <= cnt_d;
      out_vld_q <= out_vld_d;
      out_dat_q <= out_dat_d;
    end
  end

  assign out_valid = out_vld_q;
  assign out_data  = out_dat_q;
  assign busy      = (state_q != IDLE) || out_vld_q;

`ifdef NAME_ENC_STATS_EN
  logic [31:0] words_in_q, records_out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_in_q    <= '0;
      records_out_q <= '0;
    end else begin
      if (accept)                 words_in_q    <= words_in_q + 32'd1;
      if (out_vld_q && out_ready) records_out_q <= records_out_q + 32'd1;
    end
  end

  assign words_in    = words_in_q;
  assign records_out = records_out_q;
`endif

endmodule

// File: doc/name_run_encoder.md
Name: name_run_encoder

Overview:
- Compression-side counterpart of the name-field decoder.
- Accepts a stream of 128-bit name words and run-length encodes consecutive identical words.
- Emits 160-bit records: bits [159:32] hold the word, bits [31:0] hold the repeat count. The decoder reloads its countdown from bits [31:0] and replays the word that many times.
- Sits between the name-field tokenizer and the compressed-stream packer.

Parameters:
- DATA_W, 128, name word width; record width is DATA_W+32.
- MAX_RUN, 32'hFFFF_FFFF, largest count placed in one record; a longer run is split. Legal range 1..2^32-1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input beat valid
- in_ready  output  1  encoder accepts the beat this cycle
- in_data  input  DATA_W  name word
- in_last  input  1  final word of block; forces a flush of the open run
- out_valid  output  1  record valid
- out_ready  input  1  downstream accepts record
- out_data  output  DATA_W+32  {word, count[31:0]}
- busy  output  1  a run is open or a record is pending

Behaviour:
- Reset (async assert, sync release): state=IDLE, out_valid=0, out_data=0, run count=0, busy=0, in_ready=1.
- Output slot: single register. A record is held stable with out_valid=1 until out_valid&out_ready. Transfer occurs when both are high.
- slot_free = !out_valid | out_ready.
- in_ready = slot_free & (state!=FLUSH). A beat is accepted when in_valid&in_ready.
- States are IDLE, ACCUM and FLUSH.
- IDLE, accepted beat:
  - cur_word<=in_data, cnt<=1.
  - If in_last: load record {in_data,1}, stay IDLE.
  - Else: go to ACCUM.
- ACCUM, accepted beat equal to cur_word with cnt<MAX_RUN:
  - cnt<=cnt+1, no record.
  - If in_last: load record {cur_word,cnt+1}, go to IDLE.
- ACCUM, accepted beat equal to cur_word with cnt==MAX_RUN:
  - Load record {cur_word,MAX_RUN}, cnt<=1.
  - If in_last: go to FLUSH; else stay in ACCUM.
- ACCUM, accepted beat different from cur_word:
  - Load record {cur_word,cnt}, then cur_word<=in_data, cnt<=1.
  - If in_last: go to FLUSH; else stay in ACCUM.
- FLUSH:
  - in_ready=0.
  - When slot_free: load record {cur_word,cnt}, go to IDLE.
- Latency:
  - A record appears on out_valid the cycle after the beat that closed the run.
  - A run is never emitted before its terminating beat (a different word, MAX_RUN reached, or in_last).
- Simultaneous out transfer and new record load in the same cycle is legal: the slot reloads with no bubble.
- Count field is zero-extended to 32 bits. Count 0 is never emitted.
- busy = (state!=IDLE) | out_valid.
- Reset mid-run discards the open run and any pending record with no output.

Optional Feature:
- Macro NAME_ENC_STATS_EN.
- When defined, adds two output ports, each 32 bits, reset to 0 and wrapping modulo 2^32:
  - words_in, incremented per accepted beat.
  - records_out, incremented per out transfer.
- When undefined, neither port nor its counters exist, and behaviour is otherwise identical.

Test Plan:
- Words A,A,A,B with in_last on B, out_ready=1 -> records {A,3} then {B,1}; FLUSH entered for one cycle; busy low after the last transfer.
- Single word C with in_last -> one record {C,1} the next cycle; state stays IDLE.
- MAX_RUN=4, seven A's with last on the 7th -> records {A,4}, {A,3}.
- Backpressure: out_ready=0 for 10 cycles with A,B,C streaming -> in_ready drops once the slot is full; record {A,1} held stable; no beat lost; full sequence {A,1},{B,1},{C,1} on release.
- rst_n asserted asynchronously mid-run with {A,5} open -> out_valid=0 immediately; after release, input D with in_last -> {D,1} only.
- With NAME_ENC_STATS_EN, stream A,A,B(last) -> words_in=3, records_out=2.
